// File: rtl/regfile_multi_if.sv
// regfile_multi_if -- register-file bus: write port, two read ports and
// the bulk-clear handshake.
//   Clear      : one-cycle request to zero every entry
//   Busy       : high while the clear sweep runs
//   Write_Reg  : write enable; W_Addr / W_Data / W_BE form the write port
//   R_Addr_A/B : read addresses; R_Data_A/B are the read data
// master = requester (decode/writeback side), slave = register file.
interface regfile_multi_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic                  Clear;
  logic                  Busy;
  logic                  Write_Reg;
  logic [ADDR_W-1:0]     W_Addr;
  logic [DATA_W-1:0]     W_Data;
  logic [DATA_W/8-1:0]   W_BE;
  logic [ADDR_W-1:0]     R_Addr_A;
  logic [ADDR_W-1:0]     R_Addr_B;
  logic [DATA_W-1:0]     R_Data_A;
  logic [DATA_W-1:0]     R_Data_B;

  modport master (
    output Clear, Write_Reg, W_Addr, W_Data, W_BE, R_Addr_A, R_Addr_B,
    input  Busy, R_Data_A, R_Data_B
  );

  modport slave (
    input  Clear, Write_Reg, W_Addr, W_Data, W_BE, R_Addr_A, R_Addr_B,
    output Busy, R_Data_A, R_Data_B
  );
endinterface

// File: rtl/regfile_multi.sv
// regfile_multi -- parametrised 2-read / 1-write register file with
// byte-enable writes, write-to-read bypass, optional registered reads and
// a sequenced bulk-clear engine.
//   clk   : rising-edge clock
//   Reset : asynchronous active-low reset (clears array, FSM, read regs)
//   bus   : regfile_multi_if.slave (write port, read ports A/B, Clear/Busy)

// One byte lane of the write merge: enabled bytes take the new data,
// disabled bytes keep the stored value.
module regfile_multi_lane (
  input  logic       be_i,
  input  logic [7:0] new_i,
  input  logic [7:0] old_i,
  output logic [7:0] out_o
);
  assign out_o = be_i ? new_i : old_i;
endmodule

module regfile_multi #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  parameter int READ_LAT = 0
) (
  input  logic             clk,
  input  logic             Reset,
  regfile_multi_if.slave   bus
);
  localparam int DEPTH = 2**ADDR_W;
  localparam int NB    = DATA_W/8;

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              idle;
  logic              w_zero;      // write targets the hardwired zero entry
  logic              w_hit;       // a write that is allowed to land
  logic [DATA_W-1:0] w_old;
  logic [DATA_W-1:0] w_merge;

  assign idle   = (state_q == IDLE);
  assign w_zero = (ZERO_REG != 0) && (bus.W_Addr == '0);
  assign w_hit  = bus.Write_Reg && idle && !w_zero;
  assign w_old  = mem_q[bus.W_Addr];

  // Byte-merged write value; also the bypass value, since a bypassing read
  // addresses the same entry as the write.
  for (genvar k = 0; k < NB; k++) begin : g_lane
    regfile_multi_lane u_lane (
      .be_i  (bus.W_BE[k]),
      .new_i (bus.W_Data[8*k +: 8]),
      .old_i (w_old[8*k +: 8]),
      .out_o (w_merge[8*k +: 8])
    );
  end

  // Clear FSM
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (bus.Clear) state_d = SWEEP;
      end
      SWEEP: begin
        cnt_d = cnt_q + 1'b1;   // wraps to 0 after the last entry
        if (cnt_q == ADDR_W'(DEPTH-1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.Busy = (state_q == SWEEP);

  // Storage: the sweep owns the array; normal writes only land in IDLE.
  // A write in the cycle Clear is sampled is still performed.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (state_q == SWEEP) begin
      mem_q[cnt_q] <= '0;
    end else if (w_hit) begin
      mem_q[bus.W_Addr] <= w_merge;
    end
  end

  // Read value per port, bypass included
  logic [DATA_W-1:0] rdata_a_d, rdata_b_d;
  logic              byp_a, byp_b;

  assign byp_a = (BYPASS != 0) && w_hit && (bus.R_Addr_A == bus.W_Addr);
  assign byp_b = (BYPASS != 0) && w_hit && (bus.R_Addr_B == bus.W_Addr);

  always_comb begin
    rdata_a_d = mem_q[bus.R_Addr_A];
    if ((ZERO_REG != 0) && (bus.R_Addr_A == '0)) rdata_a_d = '0;
    if (byp_a) rdata_a_d = w_merge;
  end

  always_comb begin
    rdata_b_d = mem_q[bus.R_Addr_B];
    if ((ZERO_REG != 0) && (bus.R_Addr_B == '0)) rdata_b_d = '0;
    if (byp_b) rdata_b_d = w_merge;
  end

  if (READ_LAT == 1) begin : g_rd_reg
    logic [DATA_W-1:0] rdata_a_q, rdata_b_q;
    always_ff @(posedge clk or negedge Reset) begin
      if (!Reset) begin
        rdata_a_q <= '0;
        rdata_b_q <= '0;
      end else begin
        rdata_a_q <= rdata_a_d;
        rdata_b_q <= rdata_b_d;
      end
    end
    assign bus.R_Data_A = rdata_a_q;
    assign bus.R_Data_B = rdata_b_q;
  end else begin : g_rd_comb
    assign bus.R_Data_A = rdata_a_d;
    assign bus.R_Data_B = rdata_b_d;
  end
endmodule

// File: tb/tb_regfile_multi.sv
// tb_regfile_multi -- directed bench for regfile_multi. Three instances
// share one stimulus: combinational read with bypass, registered read with
// bypass, registered read without bypass. An array model checks all of
// them every cycle; literal expectations pin the model.
module tb_regfile_multi;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear, wr;
  logic [4:0]  waddr, ra, rb;
  logic [31:0] wdata;
  logic [3:0]  wbe;
  int          checks = 0;
  int          errors = 0;
  bit          chk_en = 1'b0;

  always #5 clk = ~clk;

  regfile_multi_if #(.DATA_W(32), .ADDR_W(5)) bi0 ();
  regfile_multi_if #(.DATA_W(32), .ADDR_W(5)) bi1 ();
  regfile_multi_if #(.DATA_W(32), .ADDR_W(5)) bi2 ();

  assign bi0.Clear = clear; assign bi1.Clear = clear; assign bi2.Clear = clear;
  assign bi0.Write_Reg = wr; assign bi1.Write_Reg = wr; assign bi2.Write_Reg = wr;
  assign bi0.W_Addr = waddr; assign bi1.W_Addr = waddr; assign bi2.W_Addr = waddr;
  assign bi0.W_Data = wdata; assign bi1.W_Data = wdata; assign bi2.W_Data = wdata;
  assign bi0.W_BE = wbe; assign bi1.W_BE = wbe; assign bi2.W_BE = wbe;
  assign bi0.R_Addr_A = ra; assign bi1.R_Addr_A = ra; assign bi2.R_Addr_A = ra;
  assign bi0.R_Addr_B = rb; assign bi1.R_Addr_B = rb; assign bi2.R_Addr_B = rb;

  regfile_multi #(.READ_LAT(0), .BYPASS(1)) dut0 (.clk(clk), .Reset(rst_n), .bus(bi0));
  regfile_multi #(.READ_LAT(1), .BYPASS(1)) dut1 (.clk(clk), .Reset(rst_n), .bus(bi1));
  regfile_multi #(.READ_LAT(1), .BYPASS(0)) dut2 (.clk(clk), .Reset(rst_n), .bus(bi2));

  // ---------------- model ----------------
  logic [31:0] m_mem [32];
  int          m_left;            // sweep cycles still to run, 0 = idle
  logic [31:0] m1a, m1b, m2a, m2b; // registered-read expectations

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] be);
    logic [31:0] r;
    for (int k = 0; k < 4; k++) r[8*k +: 8] = be[k] ? n[8*k +: 8] : o[8*k +: 8];
    return r;
  endfunction

  function automatic logic [31:0] rd(input logic [4:0] a, input bit byp);
    if (a == 5'd0) return 32'd0;
    if (byp && wr && m_left == 0 && waddr != 5'd0 && a == waddr)
      return merge(m_mem[a], wdata, wbe);
    return m_mem[a];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) m_mem[i] <= 32'd0;
      m_left <= 0;
      m1a <= 32'd0; m1b <= 32'd0; m2a <= 32'd0; m2b <= 32'd0;
    end else begin
      m1a <= rd(ra, 1'b1); m1b <= rd(rb, 1'b1);
      m2a <= rd(ra, 1'b0); m2b <= rd(rb, 1'b0);
      if (m_left > 0) begin
        m_mem[32 - m_left] <= 32'd0;
        m_left <= m_left - 1;
      end else begin
        if (wr && waddr != 5'd0) m_mem[waddr] <= merge(m_mem[waddr], wdata, wbe);
        if (clear) m_left <= 32;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle compare of every instance against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy0", {31'd0, bi0.Busy}, {31'd0, m_left != 0});
      chk("busy1", {31'd0, bi1.Busy}, {31'd0, m_left != 0});
      chk("busy2", {31'd0, bi2.Busy}, {31'd0, m_left != 0});
      chk("d0A", bi0.R_Data_A, rd(ra, 1'b1));
      chk("d0B", bi0.R_Data_B, rd(rb, 1'b1));
      chk("d1A", bi1.R_Data_A, m1a);
      chk("d1B", bi1.R_Data_B, m1b);
      chk("d2A", bi2.R_Data_A, m2a);
      chk("d2B", bi2.R_Data_B, m2b);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
    wr = 1'b1; waddr = a; wdata = d; wbe = be;
    step();
    wr = 1'b0; wbe = 4'h0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout t=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int nb;
    clear = 1'b0; wr = 1'b0; waddr = '0; wdata = '0; wbe = '0; ra = '0; rb = '0;
    repeat (2) @(posedge clk);
    chk_en = 1'b1;
    #1 rst_n = 1'b1;

    // 1: reset mid-operation, then a full write/read
    write(5'd3, 32'h12345678, 4'hF);
    write(5'd4, 32'h9ABCDEF0, 4'hF);
    ra = 5'd3; rb = 5'd4;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_rdA", bi0.R_Data_A, 32'd0);
    chk("rst_rdB", bi0.R_Data_B, 32'd0);
    chk("rst_busy", {31'd0, bi0.Busy}, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    write(5'd3, 32'hDEADBEEF, 4'hF);
    ra = 5'd3;
    @(negedge clk);
    chk("t1_read", bi0.R_Data_A, 32'hDEADBEEF);
    step();

    // 2: partial byte write with same-cycle bypass
    wr = 1'b1; waddr = 5'd3; wdata = 32'h11223344; wbe = 4'b0101; ra = 5'd3;
    @(negedge clk);
    chk("t2_bypass", bi0.R_Data_A, 32'hDE22BE44);
    step();
    wr = 1'b0; wbe = 4'h0;
    @(negedge clk);
    chk("t2_stored", bi0.R_Data_A, 32'hDE22BE44);
    chk("t2_lat1_byp", bi1.R_Data_A, 32'hDE22BE44);
    chk("t2_lat1_nobyp", bi2.R_Data_A, 32'hDEADBEEF);
    step();

    // 3: zero register ignores writes and never bypasses
    wr = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF; wbe = 4'hF; ra = 5'd0; rb = 5'd0;
    @(negedge clk);
    chk("t3_zeroA", bi0.R_Data_A, 32'd0);
    chk("t3_zeroB", bi0.R_Data_B, 32'd0);
    step();
    wr = 1'b0; wbe = 4'h0;
    @(negedge clk);
    chk("t3_zero_lat1", bi1.R_Data_A, 32'd0);
    step();

    // 4: preload, sweep, write during sweep ignored
    for (int i = 1; i < 32; i++) write(5'(i), 32'h01010101 * i, 4'hF);
    ra = 5'd31;
    clear = 1'b1; step(); clear = 1'b0;
    nb = 0;
    for (int k = 0; k < 40; k++) begin
      if (k == 20) begin
        wr = 1'b1; waddr = 5'd5; wdata = 32'hCAFEF00D; wbe = 4'hF; ra = 5'd5;
      end else begin
        wr = 1'b0; wbe = 4'h0;
      end
      @(negedge clk);
      if (k == 20) chk("t4_sweep_nobyp", bi0.R_Data_A, 32'd0);
      if (bi0.Busy) nb++;
      step();
    end
    chk("t4_busy_len", 32'(nb), 32'd32);
    chk("t4_busy_end", {31'd0, bi0.Busy}, 32'd0);
    for (int i = 0; i < 32; i++) begin
      ra = 5'(i); rb = 5'(31 - i);
      @(negedge clk);
      chk("t4_clrA", bi0.R_Data_A, 32'd0);
      chk("t4_clrB", bi0.R_Data_B, 32'd0);
      step();
    end

    // 5: registered read, with and without bypass
    write(5'd7, 32'h01234567, 4'hF);
    wr = 1'b1; waddr = 5'd7; wdata = 32'hA5A5A5A5; wbe = 4'hF; ra = 5'd7; rb = 5'd7;
    step();
    wr = 1'b0; wbe = 4'h0;
    @(negedge clk);
    chk("t5_byp_A", bi1.R_Data_A, 32'hA5A5A5A5);
    chk("t5_byp_B", bi1.R_Data_B, 32'hA5A5A5A5);
    chk("t5_nobyp_old", bi2.R_Data_A, 32'h01234567);
    step();
    @(negedge clk);
    chk("t5_nobyp_newA", bi2.R_Data_A, 32'hA5A5A5A5);
    chk("t5_nobyp_newB", bi2.R_Data_B, 32'hA5A5A5A5);
    step();

    // 6: reset aborts sweep at cnt=10; next sweep restarts at entry 0
    for (int i = 1; i < 26; i++) write(5'(i), 32'hF0000000 | i, 4'hF);
    clear = 1'b1; step(); clear = 1'b0;
    repeat (10) step();
    ra = 5'd20; rb = 5'd15;
    #2 rst_n = 1'b0;
    #1;
    chk("t6_busy0", {31'd0, bi0.Busy}, 32'd0);
    chk("t6_busy1", {31'd0, bi1.Busy}, 32'd0);
    chk("t6_rdA", bi0.R_Data_A, 32'd0);
    chk("t6_rdB", bi0.R_Data_B, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    write(5'd1, 32'h11111111, 4'hF);
    write(5'd2, 32'h22222222, 4'hF);
    clear = 1'b1; step(); clear = 1'b0;
    step(); step();
    ra = 5'd1; rb = 5'd2;
    @(negedge clk);
    chk("t6_restart_e1", bi0.R_Data_A, 32'd0);
    chk("t6_restart_e2", bi0.R_Data_B, 32'h22222222);
    for (int k = 0; k < 40; k++) begin
      if (!bi0.Busy) break;
      step();
    end
    chk("t6_busy_drop", {31'd0, bi0.Busy}, 32'd0);
    repeat (2) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/regfile_multi.md
Name: regfile_multi

Overview:
- Parametrised successor to the 32x32 two-read/one-write register file.
- Configurable data width, depth, read latency and register-0 hardwiring.
- Adds byte-enable writes, write-to-read bypass, and a sequenced bulk-clear engine with a Busy flag.
- Sits in the CPU datapath between decode (read addresses) and writeback (write port).

Parameters:
- DATA_W, 32, data width in bits; must be a multiple of 8.
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries.
- ZERO_REG, 1, 1 = entry 0 reads as 0 and ignores writes.
- BYPASS, 1, 1 = same-cycle write data is forwarded to matching read ports.
- READ_LAT, 0, read latency: 0 = combinational read, 1 = registered read.

Ports:
- clk  input  1  rising-edge clock.
- Reset  input  1  asynchronous, active-low reset.
- Clear  input  1  one-cycle request to zero every entry via the sweep engine.
- Busy  output  1  high while the clear sweep runs.
- Write_Reg  input  1  write enable.
- W_Addr  input  ADDR_W  write address.
- W_Data  input  DATA_W  write data.
- W_BE  input  DATA_W/8  byte enables; bit k covers W_Data[8k+7:8k].
- R_Addr_A  input  ADDR_W  read address, port A.
- R_Addr_B  input  ADDR_W  read address, port B.
- R_Data_A  output  DATA_W  read data, port A.
- R_Data_B  output  DATA_W  read data, port B.

Behaviour:
- Reset low, asynchronous:
  - All entries cleared to 0.
  - FSM forced to IDLE, sweep counter = 0, Busy = 0.
  - Registered read outputs (READ_LAT=1) = 0.
  - Reset asserted mid-sweep aborts the sweep immediately; the array is still zero from reset.
- Write, IDLE only:
  - On a rising edge with Write_Reg=1, each byte k with W_BE[k]=1 is updated; other bytes are kept.
  - W_BE=0 is a no-op.
  - With ZERO_REG=1, writes to W_Addr=0 are discarded.
- Read:
  - Raw value = entry[R_Addr]; forced to 0 when ZERO_REG=1 and R_Addr=0.
  - Bypass applies when BYPASS=1, Write_Reg=1, FSM=IDLE, R_Addr=W_Addr, and the address is not a discarded zero-register write.
  - Bypassed value = byte-merge of W_Data (enabled bytes) with the stored entry (disabled bytes).
  - Ports A and B are evaluated independently; both may hit the same address.
- Read latency:
  - READ_LAT=0: R_Data is combinational from the current-cycle addresses. Bypassed value visible in the same cycle; non-bypassed shows the old value until the edge.
  - READ_LAT=1: R_Data is registered at the rising edge from the read value (bypass included) computed that cycle. One-cycle latency; a write and read of the same address in one cycle yield the new data on the next cycle.
- Clear FSM states: IDLE, SWEEP.
  - IDLE -> SWEEP when Clear=1 on a rising edge. A write in that same cycle is still performed.
  - In SWEEP, each edge writes 0 to entry[cnt], then cnt increments.
  - SWEEP lasts exactly DEPTH cycles; after the edge that clears entry DEPTH-1, the FSM returns to IDLE and cnt wraps to 0.
  - Busy = 1 exactly while in SWEEP; it is registered, so it rises the cycle after Clear is sampled.
  - During SWEEP: Write_Reg is ignored and not queued, Clear is ignored, and bypass is disabled.
  - Reads during SWEEP return current array contents, so partially cleared data is visible.
- Widths: DATA_W/8 byte lanes; the sweep counter is ADDR_W bits and needs no overflow handling beyond wrap.

Test Plan:
1. Reset low mid-operation -> all reads 0, Busy=0. Release reset; write 0xDEADBEEF to addr 3 with W_BE=4'hF; read A=3 next cycle -> 0xDEADBEEF.
2. With entry 3 = 0xDEADBEEF, write 0x11223344 to addr 3 with W_BE=4'b0101 -> entry 3 = 0xDE22BE44. Same-cycle read (READ_LAT=0, BYPASS=1) -> 0xDE22BE44.
3. ZERO_REG=1: write 0xFFFFFFFF to addr 0 -> both ports read 0, with no bypass at addr 0.
4. Preload entries 1..31 with nonzero values; pulse Clear -> Busy high on the next cycle for exactly 32 cycles. A write to addr 5 during the sweep is ignored. Afterwards every entry reads 0 and Busy=0.
5. READ_LAT=1: write 0xA5A5A5A5 to addr 7 while R_Addr_A=R_Addr_B=7 -> both outputs show 0xA5A5A5A5 one cycle later. With BYPASS=0 the outputs show the old value one cycle later and the new value the cycle after.
6. Assert Reset for one cycle during the sweep at cnt=10 -> Busy=0 immediately and all entries 0. A subsequent Clear starts a new sweep from cnt=0.
